entity_draw_sequencer: RTL and testbench
========================================

Name: entity_draw_sequencer

Overview:
Per-frame scheduler that shares the single polygon draw engine among all game entities: ships, then asteroids, then shots.
On each frame tick it snapshots the per-class active masks. It then runs an ERASE pass over the slots that were drawn last frame, followed by a DRAW pass over the slots active this frame. Each slot is issued to the draw engine through a req/done handshake.
It sits between the game-state registers (entity active flags) and the poly draw datapath, which uses class/index to fetch geometry.

Parameters:
MAX_SHIPS, 1, number of ship slots (1..16)
MAX_ASTEROIDS, 5, number of asteroid slots (1..16)
MAX_SHOTS, 10, number of shot slots (1..16)
IDX_W, 4, width of draw_index; must hold max(MAX_*)-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle frame tick (vsync-derived)
ship_active  in  MAX_SHIPS  bit i = ship slot i alive
asteroid_active  in  MAX_ASTEROIDS  bit i = asteroid slot i alive
shot_active  in  MAX_SHOTS  bit i = shot slot i alive
draw_req  out  1  request to draw engine, held until draw_done
draw_class  out  2  0=ship, 1=asteroid, 2=shot; 3 never driven
draw_index  out  IDX_W  slot index within the class
draw_erase  out  1  1 = erase pass (draw in background colour), 0 = draw pass
draw_done  in  1  one-cycle completion pulse from the draw engine
busy  out  1  high from the cycle after an accepted frame_start through the frame_done cycle
frame_done  out  1  one-cycle pulse when both passes complete
frame_overrun  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0. cur_mask, prev_mask, pointer and state cleared. State = IDLE.
- States:
  - IDLE: on frame_start, load cur_mask from the three inputs, set pointer to (pass=ERASE, class=ship, idx=0), go to SCAN.
  - SCAN: test the bit for the current slot (ERASE pass uses prev_mask, DRAW pass uses cur_mask). If the bit is set, go to REQ. Otherwise advance the pointer and stay in SCAN. Each slot costs exactly 1 cycle.
  - REQ: draw_req=1, with draw_class, draw_index and draw_erase stable and registered. On draw_done=1, advance the pointer and go to SCAN; draw_req is 0 the following cycle.
  - DONE: frame_done=1 for one cycle, prev_mask <= cur_mask, go to IDLE.
- Pointer order: index ascending within a class; class order ship -> asteroid -> shot.
  - Past the last shot in ERASE: pass=DRAW, class=ship, idx=0.
  - Past the last shot in DRAW: go to DONE. This applies whether the transition is taken from SCAN (bit clear) or from REQ (draw_done).
- Latency:
  - frame_start sampled at cycle t gives SCAN at t+1.
  - If the first slot's bit is set, draw_req rises at t+2.
  - With no bits set in either mask, frame_done is asserted at t+1+2N, where N = MAX_SHIPS+MAX_ASTEROIDS+MAX_SHOTS (t+33 with defaults).
- Handshake rules:
  - draw_done is ignored unless the state is REQ.
  - draw_done may arrive at the earliest one cycle after draw_req rises.
  - Outputs never change while draw_req=1.
- Snapshot: the mask inputs are sampled only in IDLE on frame_start. Changes to them mid-frame have no effect until the next frame.
- Overrun: frame_start while state != IDLE pulses frame_overrun for one cycle. The tick is otherwise dropped and the current sequence is unaffected.
- Simultaneous events: frame_start in the DONE cycle counts as an overrun.
- Reset mid-operation: takes priority over everything. draw_req is 0 the next cycle and prev_mask is cleared, so the first frame after reset issues no erases.

Decomposition:
- Shared package: class encodings (CLASS_SHIP=0, CLASS_ASTR=1, CLASS_SHOT=2), pass encoding (PASS_ERASE=1, PASS_DRAW=0), FSM state localparams (IDLE, SCAN, REQ, DONE).
- Sub-module entity_slot_pointer: holds pass/class/index and provides an advance input. It outputs the current slot coordinates, a last_in_class flag and a last_slot_of_draw_pass flag.

Test Plan:
1. Reset; frame_start with ship_active=1, other masks 0; draw_done 2 cycles after each req -> no erase reqs, one req (class 0, idx 0, erase 0), then frame_done; busy low after.
2. Next frame with ship_active=0, asteroid_active=5'b00101 -> reqs in order (0,0,erase 1), (1,0,erase 0), (1,2,erase 0), then frame_done.
3. All masks 0 after reset; frame_start at t -> draw_req never rises, frame_done high exactly at t+33, busy high t+1..t+33.
4. frame_start pulsed while in REQ -> frame_overrun high for exactly 1 cycle; request sequence and frame_done timing identical to the run without the pulse.
5. shot_active toggled to all-ones mid-frame -> no shot reqs this frame; full shot draw reqs next frame.
6. reset asserted while draw_req=1 -> draw_req=0 next cycle. Next frame with ship_active=1 issues only the draw req (no erase), and draw_done pulses during IDLE are ignored.

Source files
------------

// File: rtl/entity_draw_sequencer_pkg.sv
// Shared encodings for the entity draw sequencer: entity classes, pass
// polarity and the sequencer FSM states.
package entity_draw_sequencer_pkg;

    // Entity class codes as seen by the polygon draw datapath
    localparam logic [1:0] CLASS_SHIP = 2'd0;
    localparam logic [1:0] CLASS_ASTR = 2'd1;
    localparam logic [1:0] CLASS_SHOT = 2'd2;

    // Pass polarity: erase redraws last frame's slots in background colour
    localparam logic PASS_ERASE = 1'b1;
    localparam logic PASS_DRAW  = 1'b0;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/entity_draw_sequencer_slot_pointer.sv
// Slot pointer: walks (pass, class, index) in the order
// erase{ship, asteroid, shot} then draw{ship, asteroid, shot}, index ascending.
module entity_slot_pointer
    import entity_draw_sequencer_pkg::*;
#(
    parameter int MAX_SHIPS     = 1,
    parameter int MAX_ASTEROIDS = 5,
    parameter int MAX_SHOTS     = 10,
    parameter int IDX_W         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_advance,
    output logic             o_pass,
    output logic [1:0]       o_class,
    output logic [IDX_W-1:0] o_index,
    output logic             o_last_in_class,
    output logic             o_last_slot_of_draw_pass
);

    localparam logic [IDX_W-1:0] LAST_SHIP = IDX_W'(MAX_SHIPS - 1);
    localparam logic [IDX_W-1:0] LAST_ASTR = IDX_W'(MAX_ASTEROIDS - 1);
    localparam logic [IDX_W-1:0] LAST_SHOT = IDX_W'(MAX_SHOTS - 1);

    logic             r_pass;
    logic [1:0]       r_class;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_last_idx;

    // Highest valid index for the class currently pointed at
    always_comb begin
        w_last_idx = LAST_SHOT;
        case (r_class)
            CLASS_SHIP: w_last_idx = LAST_SHIP;
            CLASS_ASTR: w_last_idx = LAST_ASTR;
            CLASS_SHOT: w_last_idx = LAST_SHOT;
            default:    w_last_idx = LAST_SHOT;
        endcase
    end

    assign o_last_in_class          = (r_index == w_last_idx);
    assign o_last_slot_of_draw_pass = (r_pass == PASS_DRAW) && (r_class == CLASS_SHOT)
                                      && o_last_in_class;
    assign o_pass  = r_pass;
    assign o_class = r_class;
    assign o_index = r_index;

    // Pointer register: load to the first erase slot, or step to the next slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pass  <= 1'b0;
            r_class <= 2'd0;
            r_index <= '0;
        end else if (i_load) begin
            r_pass  <= PASS_ERASE;
            r_class <= CLASS_SHIP;
            r_index <= '0;
        end else if (i_advance) begin
            if (o_last_in_class) begin
                r_index <= '0;
                if (r_class == CLASS_SHOT) begin
                    // End of the erase pass rolls into the draw pass; the end of
                    // the draw pass is never advanced past (the FSM finishes).
                    r_pass  <= PASS_DRAW;
                    r_class <= CLASS_SHIP;
                end else begin
                    r_class <= r_class + 2'd1;
                end
            end else begin
                r_index <= r_index + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/entity_draw_sequencer.sv
// Per-frame scheduler sharing the polygon draw engine between ships,
// asteroids and shots: erase last frame's slots, then draw this frame's.
module entity_draw_sequencer
    import entity_draw_sequencer_pkg::*;
#(
    parameter int MAX_SHIPS     = 1,
    parameter int MAX_ASTEROIDS = 5,
    parameter int MAX_SHOTS     = 10,
    parameter int IDX_W         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_start,
    input  logic [MAX_SHIPS-1:0]     ship_active,
    input  logic [MAX_ASTEROIDS-1:0] asteroid_active,
    input  logic [MAX_SHOTS-1:0]     shot_active,
    output logic                     draw_req,
    output logic [1:0]               draw_class,
    output logic [IDX_W-1:0]         draw_index,
    output logic                     draw_erase,
    input  logic                     draw_done,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_overrun
);

    localparam int EXT_W = 1 << IDX_W;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [MAX_SHIPS-1:0]     r_cur_ship,  r_prev_ship;
    logic [MAX_ASTEROIDS-1:0] r_cur_astr,  r_prev_astr;
    logic [MAX_SHOTS-1:0]     r_cur_shot,  r_prev_shot;

    logic                     w_load, w_advance;
    logic                     w_pass, w_last_in_class, w_last_draw, w_frame_end;
    logic [1:0]               w_class;
    logic [IDX_W-1:0]         w_index;
    logic [EXT_W-1:0]         w_sel_mask;
    logic                     w_slot_bit;

    logic                     r_draw_req, r_draw_erase, r_busy, r_frame_done, r_overrun;
    logic [1:0]               r_draw_class;
    logic [IDX_W-1:0]         r_draw_index;

    entity_slot_pointer #(
        .MAX_SHIPS     (MAX_SHIPS),
        .MAX_ASTEROIDS (MAX_ASTEROIDS),
        .MAX_SHOTS     (MAX_SHOTS),
        .IDX_W         (IDX_W)
    ) u_ptr (
        .clk                      (clk),
        .reset                    (reset),
        .i_load                   (w_load),
        .i_advance                (w_advance),
        .o_pass                   (w_pass),
        .o_class                  (w_class),
        .o_index                  (w_index),
        .o_last_in_class          (w_last_in_class),
        .o_last_slot_of_draw_pass (w_last_draw)
    );

    // Final slot of the final class in the draw pass ends the frame
    assign w_frame_end = w_last_draw && w_last_in_class;

    // Select the active mask for the pointed-at class and pass, zero-padded
    always_comb begin
        w_sel_mask = '0;
        case (w_class)
            CLASS_SHIP: begin
                for (int i = 0; i < MAX_SHIPS; i++)
                    w_sel_mask[i] = (w_pass == PASS_ERASE) ? r_prev_ship[i] : r_cur_ship[i];
            end
            CLASS_ASTR: begin
                for (int i = 0; i < MAX_ASTEROIDS; i++)
                    w_sel_mask[i] = (w_pass == PASS_ERASE) ? r_prev_astr[i] : r_cur_astr[i];
            end
            CLASS_SHOT: begin
                for (int i = 0; i < MAX_SHOTS; i++)
                    w_sel_mask[i] = (w_pass == PASS_ERASE) ? r_prev_shot[i] : r_cur_shot[i];
            end
            default: w_sel_mask = '0;
        endcase
    end

    assign w_slot_bit = w_sel_mask[w_index];

    // Next-state and pointer control
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SCAN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_slot_bit) begin
                    w_state_next = ST_REQ;
                end else if (w_frame_end) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = ST_SCAN;
                end
            end
            ST_REQ: begin
                if (draw_done) begin
                    if (w_frame_end) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_state_next = ST_SCAN;
                    end
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Mask snapshot at frame start; current becomes previous when the frame ends
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_ship  <= '0;
            r_cur_astr  <= '0;
            r_cur_shot  <= '0;
            r_prev_ship <= '0;
            r_prev_astr <= '0;
            r_prev_shot <= '0;
        end else begin
            if ((r_state == ST_IDLE) && frame_start) begin
                r_cur_ship <= ship_active;
                r_cur_astr <= asteroid_active;
                r_cur_shot <= shot_active;
            end
            if (r_state == ST_DONE) begin
                r_prev_ship <= r_cur_ship;
                r_prev_astr <= r_cur_astr;
                r_prev_shot <= r_cur_shot;
            end
        end
    end

    // Registered outputs derived from the state being entered; slot coordinates
    // are captured only on entry to REQ so they hold steady during a request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_draw_req   <= 1'b0;
            r_draw_class <= 2'd0;
            r_draw_index <= '0;
            r_draw_erase <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_draw_req <= (w_state_next == ST_REQ);
            if ((w_state_next == ST_REQ) && (r_state != ST_REQ)) begin
                r_draw_class <= w_class;
                r_draw_index <= w_index;
                r_draw_erase <= (w_pass == PASS_ERASE);
            end
            r_busy       <= (w_state_next != ST_IDLE);
            r_frame_done <= (w_state_next == ST_DONE);
            r_overrun    <= frame_start && (r_state != ST_IDLE);
        end
    end

    assign draw_req      = r_draw_req;
    assign draw_class    = r_draw_class;
    assign draw_index    = r_draw_index;
    assign draw_erase    = r_draw_erase;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_entity_draw_sequencer.sv
// Bench for entity_draw_sequencer: expected request lists come from the
// active masks (erase last frame's set, then draw this frame's set) and
// expected frame_done timing from slot and handshake cycle costs.
module tb_entity_draw_sequencer;

    localparam int NS = 1;
    localparam int NA = 5;
    localparam int NH = 10;
    localparam int IW = 4;
    localparam int NTOT = NS + NA + NH;

    typedef struct packed {
        logic [1:0]    cls;
        logic [IW-1:0] idx;
        logic          er;
    } req_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [NS-1:0] ship_active = '0;
    logic [NA-1:0] asteroid_active = '0;
    logic [NH-1:0] shot_active = '0;
    logic          draw_done = 1'b0;
    logic          draw_req, draw_erase, busy, frame_done, frame_overrun;
    logic [1:0]    draw_class;
    logic [IW-1:0] draw_index;

    int checks = 0;
    int failures = 0;

    logic [NS-1:0] m_prev_s = '0;
    logic [NA-1:0] m_prev_a = '0;
    logic [NH-1:0] m_prev_h = '0;
    req_t          exp_q[$];

    entity_draw_sequencer #(
        .MAX_SHIPS(NS), .MAX_ASTEROIDS(NA), .MAX_SHOTS(NH), .IDX_W(IW)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .ship_active(ship_active), .asteroid_active(asteroid_active),
        .shot_active(shot_active), .draw_req(draw_req), .draw_class(draw_class),
        .draw_index(draw_index), .draw_erase(draw_erase), .draw_done(draw_done),
        .busy(busy), .frame_done(frame_done), .frame_overrun(frame_overrun)
    );

    always #5 clk = ~clk;

    // Expected request list: erase every slot alive last frame, then draw
    // every slot alive in the new snapshot, ships/asteroids/shots, index ascending.
    task automatic build_expected(input logic [NS-1:0] s, input logic [NA-1:0] a,
                                  input logic [NH-1:0] h);
        req_t r;
        exp_q.delete();
        for (int p = 1; p >= 0; p--) begin
            for (int i = 0; i < NS; i++)
                if ((p == 1) ? m_prev_s[i] : s[i]) begin
                    r.cls = 2'd0; r.idx = IW'(i); r.er = 1'(p); exp_q.push_back(r);
                end
            for (int i = 0; i < NA; i++)
                if ((p == 1) ? m_prev_a[i] : a[i]) begin
                    r.cls = 2'd1; r.idx = IW'(i); r.er = 1'(p); exp_q.push_back(r);
                end
            for (int i = 0; i < NH; i++)
                if ((p == 1) ? m_prev_h[i] : h[i]) begin
                    r.cls = 2'd2; r.idx = IW'(i); r.er = 1'(p); exp_q.push_back(r);
                end
        end
    endtask

    // One complete frame: frame_start in cycle 0, serve requests, check order,
    // stability, busy, overrun and frame_done timing against the model.
    task automatic run_frame(input logic [NS-1:0] s, input logic [NA-1:0] a,
                             input logic [NH-1:0] h, input int dly, input bit ovr_in_req,
                             input bit toggle_shots, input bit spurious, input string name);
        int   done_seen, done_at, d, exp_done, busy_err, stab_err, ovr_cnt, ovr_at, ovr_bad;
        req_t held, obs;
        logic prev_req, prev_done;
        build_expected(s, a, h);
        exp_done = 1 + 2 * NTOT;
        done_seen = -1; done_at = -1; ovr_at = -1;
        busy_err = 0; stab_err = 0; ovr_cnt = 0; ovr_bad = 0;
        prev_req = 1'b0; prev_done = 1'b0; held = '0;
        @(posedge clk); #1;
        ship_active = s; asteroid_active = a; shot_active = h;
        frame_start = 1'b1; draw_done = 1'b0;
        for (int k = 1; k <= 800 && done_seen < 0; k++) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            if (k == 3 && toggle_shots) shot_active = '1;
            if (frame_overrun) begin
                ovr_cnt++;
                if (k != ovr_at + 1) ovr_bad++;
            end
            if (!busy) busy_err++;
            if (prev_done && prev_req && draw_req) stab_err++;
            obs = {draw_class, draw_index, draw_erase};
            if (draw_req && !prev_req) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s req_order: got unexpected req %h, expected none", name, obs);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL %s req_order: got cls/idx/er %h, expected %h", name, obs, e);
                    end
                end
                held = obs;
                d = (dly > 0) ? dly : int'($urandom_range(1, 3));
                done_at = k + d;
                exp_done += 1 + d;
                if (ovr_in_req && ovr_at < 0) begin
                    frame_start = 1'b1;
                    ovr_at = k;
                end
            end else if (draw_req && obs !== held) begin
                stab_err++;
            end
            if (draw_req && k == done_at) draw_done = 1'b1;
            else if (!draw_req && spurious && $urandom_range(0, 3) == 0) draw_done = 1'b1;
            else draw_done = 1'b0;
            prev_done = draw_done;
            prev_req = draw_req;
            if (frame_done) done_seen = k;
        end
        draw_done = 1'b0;
        checks++;
        if (done_seen != exp_done) begin
            failures++;
            $display("FAIL %s done_time: got cycle %0d, expected %0d", name, done_seen, exp_done);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_reqs: got %0d outstanding, expected 0", name, exp_q.size());
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy_high: got %0d low cycles, expected 0", name, busy_err);
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL %s req_stable: got %0d unstable cycles, expected 0", name, stab_err);
        end
        checks++;
        if (ovr_cnt != ((ovr_at >= 0) ? 1 : 0) || ovr_bad != 0) begin
            failures++;
            $display("FAIL %s overrun: got %0d pulses (%0d misplaced), expected %0d",
                     name, ovr_cnt, ovr_bad, (ovr_at >= 0) ? 1 : 0);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, frame_done, draw_req} !== 3'b000) begin
            failures++;
            $display("FAIL %s after_done: got busy/done/req %b, expected 000",
                     name, {busy, frame_done, draw_req});
        end
        m_prev_s = s; m_prev_a = a; m_prev_h = h;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (draw_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b, expected 0", draw_req); end
        checks++;
        if ({draw_class, draw_index, draw_erase} !== 7'd0) begin
            failures++; $display("FAIL reset_coord: got %h, expected 0", {draw_class, draw_index, draw_erase});
        end
        checks++;
        if ({busy, frame_done, frame_overrun} !== 3'b000) begin
            failures++; $display("FAIL reset_status: got %b, expected 000", {busy, frame_done, frame_overrun});
        end
        reset = 1'b0;
        m_prev_s = '0; m_prev_a = '0; m_prev_h = '0;
    endtask

    task automatic test_empty_frame();
        run_frame('0, '0, '0, 2, 1'b0, 1'b0, 1'b0, "empty_frame");
    endtask

    task automatic test_single_ship();
        run_frame(1'b1, '0, '0, 2, 1'b0, 1'b0, 1'b0, "single_ship");
    endtask

    task automatic test_erase_then_draw();
        run_frame(1'b0, 5'b00101, '0, 2, 1'b0, 1'b0, 1'b0, "erase_then_draw");
    endtask

    task automatic test_overrun();
        run_frame(1'b1, 5'b10010, 10'b0000000110, 0, 1'b1, 1'b0, 1'b0, "overrun");
    endtask

    task automatic test_snapshot();
        run_frame(1'b0, 5'b01000, '0, 1, 1'b0, 1'b1, 1'b0, "snapshot_mid");
        run_frame(1'b0, 5'b01000, '1, 1, 1'b0, 1'b0, 1'b0, "snapshot_next");
    endtask

    task automatic test_reset_mid_req();
        int waited, idle_err;
        @(posedge clk); #1;
        ship_active = 1'b1; asteroid_active = '0; shot_active = '0;
        frame_start = 1'b1;
        waited = 0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        while (!draw_req && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (!draw_req) begin
            failures++; $display("FAIL reset_mid wait_req: got no req in %0d cycles, expected req", waited);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({draw_req, busy} !== 2'b00) begin
            failures++; $display("FAIL reset_mid req_drop: got req/busy %b, expected 00", {draw_req, busy});
        end
        m_prev_s = '0; m_prev_a = '0; m_prev_h = '0;
        idle_err = 0;
        for (int i = 0; i < 6; i++) begin
            draw_done = (i % 2 == 0) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            if (draw_req || busy || frame_done) idle_err++;
        end
        draw_done = 1'b0;
        checks++;
        if (idle_err != 0) begin
            failures++; $display("FAIL reset_mid idle_done: got %0d active cycles, expected 0", idle_err);
        end
        run_frame(1'b1, '0, '0, 2, 1'b0, 1'b0, 1'b0, "post_reset_frame");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 8; f++)
            run_frame(NS'($urandom()), NA'($urandom()), NH'($urandom()), 0, 1'b0, 1'b0,
                      1'b1, "random_frame");
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_single_ship();
        test_erase_then_draw();
        test_overrun();
        test_snapshot();
        test_reset_mid_req();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
